// File: rtl/icache_axi_refill_pkg.sv
// Shared AXI4 read-channel constants and refill FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_axi_refill_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } refill_state_e;

    // Clear the low off_w address bits so the burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] a, input int unsigned off_w);
        return a & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_axi_refill.sv
// I-cache line refill over AXI4 read: one INCR burst of BURST_LEN 32-bit beats per request.
// Latency: read_req to first read_valid is 3 cycles minimum (latch, AR handshake, registered beat).
// Backpressure: AR waits on arready; R is always accepted in DATA, so the cache sees no stall.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int unsigned BURST_LEN = 16,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req,
    input  logic [31:0] addr_req,
    output logic        req_ok,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        read_last,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err,
    output logic        proto_err
);

    localparam int unsigned    CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned    OFF_W    = $clog2(BURST_LEN * 4);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    refill_state_e    state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;
    logic             read_last_q, read_last_d;
    logic             bus_err_q, bus_err_d;
    logic             proto_err_q, proto_err_d;

    logic beat;
    logic cnt_at_last;

    // The response ID carries no information for a single outstanding burst.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign beat        = rvalid && (state_q == ST_DATA);
    assign cnt_at_last = (cnt_q == LAST_CNT);

    // Refill sequencing: latch aligned address, issue AR, count R beats until the line is full.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (read_req) begin
                    addr_d  = line_align(addr_req, OFF_W);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_at_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat forwarding and sticky error capture; last is taken from our own count, never from rlast.
    always_comb begin
        read_valid_d = beat;
        read_last_d  = beat && cnt_at_last;
        read_data_d  = beat ? rdata : read_data_q;
        bus_err_d    = bus_err_q   | (beat && (rresp != RESP_OKAY));
        proto_err_d  = proto_err_q | (beat && (rlast != cnt_at_last));
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            read_last_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            read_last_q  <= read_last_d;
            bus_err_q    <= bus_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // AR fields come straight from state and the latched address, so they hold while arvalid waits.
    assign arvalid = (state_q == ST_ADDR);
    assign araddr  = addr_q;
    assign arid    = AXI_ID;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign rready  = (state_q == ST_DATA);

    // Accept the request on the AR handshake, then keep acknowledging it for the rest of the burst.
    assign req_ok  = ((state_q == ST_ADDR) && arready) || ((state_q == ST_DATA) && read_req);

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign read_last  = read_last_q;
    assign bus_err    = bus_err_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for the AXI refill engine with a beat/AR scoreboard and an independent monitor.
module tb_icache_axi_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_req = 1'b0;
    logic [31:0] addr_req = '0;
    logic        req_ok;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        bus_err;
    logic        proto_err;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] ar_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        beat_fire = 1'b0;
    logic        pend = 1'b0;

    always #5 clk = ~clk;

    icache_axi_refill #(
        .BURST_LEN (16),
        .AXI_ID    (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_req   (read_req),
        .addr_req   (addr_req),
        .req_ok     (req_ok),
        .read_data  (read_data),
        .read_valid (read_valid),
        .read_last  (read_last),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .bus_err    (bus_err),
        .proto_err  (proto_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_arvalid"},    arvalid,    0);
        chk({tag, "_rready"},     rready,     0);
        chk({tag, "_req_ok"},     req_ok,     0);
        chk({tag, "_read_valid"}, read_valid, 0);
        chk({tag, "_read_last"},  read_last,  0);
        chk({tag, "_bus_err"},    bus_err,    0);
        chk({tag, "_proto_err"},  proto_err,  0);
        chk({tag, "_read_data"},  read_data,  0);
        chk({tag, "_araddr"},     araddr,     0);
    endtask

    // Monitor: read_valid must echo the accepted-beat pattern one cycle late; beats and ARs pop the scoreboard.
    initial begin
        beat_t b;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("read_valid_pattern", read_valid, pend);
                if (read_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected got=%h want=none", read_data);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", read_data, b.d);
                        chk("beat_last", read_last, b.l);
                    end
                end else begin
                    chk("read_last_idle", read_last, 0);
                end
                if (arvalid && arready) begin
                    checks++;
                    if (ar_q.size() == 0) begin
                        errors++;
                        $display("FAIL ar_unexpected got=%h want=none", araddr);
                    end else begin
                        ea = ar_q.pop_front();
                        chk("ar_addr",  araddr,  ea);
                        chk("ar_len",   arlen,   8'd15);
                        chk("ar_size",  arsize,  3'b010);
                        chk("ar_burst", arburst, 2'b01);
                        chk("ar_id",    arid,    4'd0);
                    end
                end
                pend = beat_fire;
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Request from IDLE: AR must appear one cycle later and hold for ar_wait cycles without arready.
    task automatic issue(input logic [31:0] a, input int ar_wait, input logic [31:0] ea, input bit keep);
        read_req = 1'b1;
        addr_req = a;
        ar_q.push_back(ea);
        step();
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            chk("ar_hold_vld",    arvalid, 1);
            chk("ar_hold_addr",   araddr,  ea);
            chk("ar_hold_req_ok", req_ok,  0);
            chk("ar_hold_rready", rready,  0);
            step();
        end
        arready = 1'b1;
        @(negedge clk);
        chk("arvalid_hs", arvalid, 1);
        chk("req_ok_hs",  req_ok,  1);
        step();
        arready = 1'b0;
        if (!keep) read_req = 1'b0;
    endtask

    // Drive 16 beats (optionally alternate-cycle), with optional bad rlast / error response / reset abort.
    task automatic burst(input logic [31:0] base, input bit gap, input int rlast_beat, input int err_beat,
                         input int abort_beat, input logic [31:0] ea, input bit pre_bus, input bit pre_proto);
        for (int k = 0; k < 16; k++) begin
            rvalid    = 1'b1;
            rdata     = base + 32'(k);
            rlast     = (k == rlast_beat) || (k == 15);
            rresp     = (k == err_beat) ? 2'b10 : 2'b00;
            rid       = 4'(k);
            beat_fire = 1'b1;
            if (k == abort_beat) begin
                #2 rst = 1'b0;
                #1 reset_checks("abort");
                exp_q.delete();
                beat_fire = 1'b0;
                rvalid    = 1'b0;
                rlast     = 1'b0;
                return;
            end
            exp_q.push_back('{d: base + 32'(k), l: (k == 15)});
            @(negedge clk);
            chk("data_rready",   rready,  1);
            chk("data_no_ar",    arvalid, 0);
            chk("data_req_ok",   req_ok,  read_req);
            chk("data_araddr",   araddr,  ea);
            chk("data_bus_err",  bus_err,   pre_bus   || (err_beat >= 0 && k > err_beat));
            chk("data_proto_err", proto_err, pre_proto || (rlast_beat < 15 && k > rlast_beat));
            step();
            if (gap && k != 15) begin
                rvalid    = 1'b0;
                beat_fire = 1'b0;
                step();
            end
        end
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rresp     = 2'b00;
        beat_fire = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_checks("por");
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", arvalid, 0);

        // Aligned 16-beat refill, immediate arready.
        issue(32'h1234_5678, 0, 32'h1234_5640, 1'b0);
        burst(32'h0, 1'b0, 15, -1, -1, 32'h1234_5640, 1'b0, 1'b0);
        repeat (3) step();
        chk("s1_bus_err",   bus_err,   0);
        chk("s1_proto_err", proto_err, 0);

        // arready stalled 5 cycles, R beats on alternate cycles.
        issue(32'h0000_8010, 5, 32'h0000_8000, 1'b0);
        burst(32'h100, 1'b1, 15, -1, -1, 32'h0000_8000, 1'b0, 1'b0);
        repeat (3) step();

        // Early rlast on beat 7 and SLVERR on beat 3: flags stick, beats still forwarded.
        issue(32'hABCD_EF7C, 0, 32'hABCD_EF40, 1'b0);
        burst(32'h200, 1'b0, 7, 3, -1, 32'hABCD_EF40, 1'b0, 1'b0);
        repeat (3) step();
        chk("s3_bus_err",   bus_err,   1);
        chk("s3_proto_err", proto_err, 1);

        // Reset during beat 9, then a clean refill at 0x40.
        issue(32'h0000_3000, 0, 32'h0000_3000, 1'b0);
        burst(32'h300, 1'b0, 15, -1, 9, 32'h0000_3000, 1'b1, 1'b1);
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_arvalid",    arvalid,    0);
        chk("post_abort_rready",     rready,     0);
        chk("post_abort_read_valid", read_valid, 0);
        issue(32'h0000_0040, 0, 32'h0000_0040, 1'b0);
        burst(32'h400, 1'b0, 15, -1, -1, 32'h0000_0040, 1'b0, 1'b0);
        repeat (3) step();
        chk("s4_bus_err",   bus_err,   0);
        chk("s4_proto_err", proto_err, 0);

        // read_req held through DATA with a new address; next AR exactly two cycles after the last beat.
        issue(32'h0000_2004, 0, 32'h0000_2000, 1'b1);
        addr_req = 32'h1000_1234;
        burst(32'h500, 1'b0, 15, -1, -1, 32'h0000_2000, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_no_ar_t1", arvalid, 0);
        issue(32'h1000_1234, 0, 32'h1000_1200, 1'b0);
        burst(32'h600, 1'b0, 15, -1, -1, 32'h1000_1200, 1'b0, 1'b0);

        repeat (4) step();
        chk("beats_drained", exp_q.size(), 0);
        chk("ars_drained",   ar_q.size(),  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
ICACHE_AXI_REFILL -- requirements
Module: icache_axi_refill

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, beats per refill (power of two, 2..256).
REQ-002 SHALL have parameter AXI_ID, default 4'd0, constant arid value.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port read_req  input  1  cache refill request, held until req_ok.
REQ-006 SHALL have port addr_req  input  32  refill address.
REQ-007 SHALL have port req_ok  output  1  request accepted / burst in progress.
REQ-008 SHALL have port read_data  output  32  refill beat data.
REQ-009 SHALL have port read_valid  output  1  read_data valid this cycle.
REQ-010 SHALL have port read_last  output  1  final beat of the refill.
REQ-011 SHALL have AXI4 read ports arid(out,4), araddr(out,32), arlen(out,8), arsize(out,3), arburst(out,2), arvalid(out,1), arready(in,1), rid(in,4), rdata(in,32), rresp(in,2), rlast(in,1), rvalid(in,1), rready(out,1).
REQ-012 SHALL have ports bus_err output 1 (sticky, rresp != OKAY) and proto_err output 1 (sticky, rlast mismatch).

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-014 IDLE: on read_req=1, SHALL latch addr_req with low log2(BURST_LEN*4) bits cleared and go to ADDR next cycle.
REQ-015 ADDR: arvalid SHALL be 1, araddr = latched address, arlen = BURST_LEN-1, arsize = 3'b010, arburst = INCR, arid = AXI_ID; all AR fields stable while arvalid=1.
REQ-016 ADDR: on arvalid&&arready, req_ok SHALL be 1 in that same cycle and FSM SHALL go to DATA.
REQ-017 DATA: req_ok SHALL be 1 whenever read_req=1; read_req/addr_req SHALL NOT be re-latched in DATA.
REQ-018 DATA: rready SHALL be 1 constantly (cache side has no backpressure); rready=0 in IDLE and ADDR.
REQ-019 Each rvalid&&rready beat SHALL be registered: read_data=rdata, read_valid=1 exactly one cycle later; read_valid=0 otherwise.
REQ-020 Beat counter (log2(BURST_LEN) bits) SHALL clear on entry to DATA and increment per accepted beat.
REQ-021 read_last SHALL be 1 with the registered beat whose counter value is BURST_LEN-1, derived from the counter, not rlast.
REQ-022 On that final beat FSM SHALL return to IDLE; a read_req present in IDLE the following cycle SHALL start a new request (ADDR one cycle later).
REQ-023 rlast=1 on counter != BURST_LEN-1, or rlast=0 on counter == BURST_LEN-1, SHALL set proto_err; beat still forwarded.
REQ-024 rresp != 2'b00 on any beat SHALL set bus_err; beat still forwarded unchanged.
REQ-025 rid SHALL be ignored.
REQ-026 bus_err/proto_err SHALL clear only on reset.
REQ-027 Minimum latency read_req to first read_valid SHALL be 3 cycles (IDLE latch, ADDR with arready=1, first rvalid in DATA, registered output).

Reset
REQ-028 While rst=0, state SHALL be IDLE and arvalid, rready, req_ok, read_valid, read_last, bus_err, proto_err, read_data, araddr, counter SHALL be 0.
REQ-029 Reset asserted mid-ADDR or mid-DATA SHALL abort immediately; no further beats forwarded; first post-reset cycle in IDLE.

Structure
REQ-030 Shared package SHALL hold AXI constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00) and the refill FSM state enum.
REQ-031 Block SHALL be a single module with no sub-modules.

Verification
REQ-032 addr_req=0x1234_5678, read_req=1, arready=1 immediately, 16 beats rdata=k, rresp=0, rlast on beat 15 -> araddr=0x1234_5640, arlen=15, 16 read_valid pulses data 0..15, read_last only on 16th, no errors.
REQ-033 arready held 0 for 5 cycles -> arvalid and araddr stable 5 cycles, req_ok=0 until handshake cycle.
REQ-034 rvalid gaps (beats on alternate cycles) -> read_valid mirrors pattern one cycle later, counter correct, read_last on 16th beat.
REQ-035 rlast=1 on beat 7, rresp=2'b10 on beat 3 -> proto_err and bus_err set and stay set; read_last still on beat 16.
REQ-036 rst=0 during beat 9 -> outputs 0 asynchronously; after release new request at 0x0000_0040 completes normally.
REQ-037 read_req held through DATA and re-asserted cycle after read_last -> no second AR during DATA; second AR issued exactly 2 cycles after last beat handshake.
